caesar_encryption: RTL and testbench
====================================

CAESAR_ENCRYPTION -- requirements
Module: caesar_encryption

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width in bits (KEY_WIDTH >= D_WIDTH).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_i  input  D_WIDTH  plaintext word.
REQ-007 SHALL have port valid_i  input  1  data_i valid this cycle.
REQ-008 SHALL have port key  input  KEY_WIDTH  encryption key.
REQ-009 SHALL have port ready_i  input  1  downstream accepts data_o this cycle.
REQ-010 SHALL have port data_o  output  D_WIDTH  ciphertext word, registered.
REQ-011 SHALL have port valid_o  output  1  data_o valid, registered.
REQ-012 SHALL have port busy  output  1  input buffer full, registered; writes refused.

Function
REQ-013 SHALL encrypt each word as (data_i + key[D_WIDTH-1:0]) mod 2^D_WIDTH; upper key bits are ignored, so that decryption by subtracting the key and truncating to D_WIDTH bits restores the plaintext.
REQ-014 SHALL accept a word on an edge where valid_i=1 and busy=0; valid_i=1 with busy=1 drops the word silently, with no state change.
REQ-015 SHALL encrypt at accept time and store ciphertext in a FIFO_DEPTH-entry FIFO, with order preserved.
REQ-016 SHALL implement two states: IDLE (FIFO empty, valid_o=0) and ACTIVE.
REQ-017 In IDLE, an accept SHALL latch key into key_q, encrypt that word with the live key, and move to ACTIVE.
REQ-018 In ACTIVE, accepted words SHALL be encrypted with key_q; key changes during ACTIVE SHALL have no effect.
REQ-019 ACTIVE SHALL return to IDLE on the edge after which the FIFO is empty, valid_o=0, and no word was accepted.
REQ-020 Output register SHALL load the FIFO head when FIFO is non-empty and (valid_o=0 or ready_i=1).
REQ-021 Holding: while valid_o=1 and ready_i=0, data_o and valid_o SHALL remain stable.
REQ-022 When valid_o=1, ready_i=1 and FIFO is empty, valid_o SHALL drop to 0 and data_o SHALL become 0.
REQ-023 data_o SHALL be 0 whenever valid_o=0.
REQ-024 Latency SHALL be 2 edges minimum: accept at edge N, valid_o=1 after edge N+1, with no combinational path from inputs to outputs.
REQ-025 Simultaneous push and pop on one edge SHALL leave the FIFO count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 busy SHALL equal (next FIFO count == FIFO_DEPTH), registered, so it is valid in the same cycle the FIFO is full.
REQ-027 Total storage SHALL be FIFO_DEPTH + 1 words (FIFO plus output register).

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force data_o=0, valid_o=0, busy=0, FIFO count=0, both pointers=0, key_q=0 and state IDLE.
REQ-029 Reset mid-burst SHALL discard all buffered words; after release the block behaves as after power-up.
REQ-030 The first accept is possible on the first rising edge with rst_n=1.

Verification
REQ-031 Basic: key=16'h0003, one-cycle valid_i with data_i=8'h41, ready_i=1 -> after 2 edges valid_o=1 for exactly 1 cycle with data_o=8'h44, then valid_o=0 and data_o=8'h00.
REQ-032 Wrap: key=16'h0105, data_i=8'hFD -> data_o=8'h02 (upper key byte ignored).
REQ-033 Backpressure: key=0, ready_i=0, valid_i held 6 cycles with 8'h10..8'h15 -> busy=1 after 8'h14 is accepted and 8'h15 is dropped; data_o holds 8'h10; raising ready_i yields 8'h10..8'h14 in order and busy falls after the first pop.
REQ-034 Key lock: burst of 3 words 8'h20 with key=1, key changed to 9 after the first accept -> outputs are 8'h21 x3; after return to IDLE, a new word 8'h20 -> 8'h29.
REQ-035 Async reset: assert rst_n=0 mid-cycle while valid_o=1 and FIFO holds 2 words -> data_o=0, valid_o=0 and busy=0 before the next edge; after release, no stale word ever appears.
REQ-036 Round trip: random words and keys, output fed to caesar_decryption with the same key -> recovered data equals the input stream exactly.

Source files
------------

// File: rtl/caesar_encryption.sv
// ---------------------------------------------------------------------------
// caesar_encryption
//
// Streaming Caesar-style encryptor. Each accepted plaintext word is shifted by
// the low D_WIDTH bits of the key (modulo 2^D_WIDTH). The ciphertext is
// computed at accept time, queued in a small FIFO and presented through a
// registered valid/ready output stage.
//
// The key is sampled when a burst starts (IDLE -> ACTIVE). It then stays locked
// until the block has fully drained and returns to IDLE, so a burst is always
// encrypted with a single key.
//
// Parameters
//   D_WIDTH    : data word width in bits
//   KEY_WIDTH  : key width in bits (>= D_WIDTH, upper bits ignored)
//   FIFO_DEPTH : input buffer entries (power of two, >= 2)
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_i   in   plaintext word
//   valid_i  in   data_i valid this cycle
//   key      in   encryption key
//   ready_i  in   downstream accepts data_o this cycle
//   data_o   out  ciphertext word, registered, 0 when valid_o=0
//   valid_o  out  data_o valid, registered
//   busy     out  FIFO full, registered; valid_i is ignored while set
// ---------------------------------------------------------------------------
module caesar_encryption #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 ready_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // State
  state_e              r_state;
  state_e              w_state_d;
  logic [D_WIDTH-1:0]  r_key_q;
  logic [D_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic [D_WIDTH-1:0]  r_data_o;
  logic                r_valid_o;
  logic                r_busy;

  // Combinational
  logic                w_push;
  logic                w_pop;
  logic [CntW-1:0]     w_count_d;
  logic [D_WIDTH-1:0]  w_data_d;
  logic                w_valid_d;
  logic [D_WIDTH-1:0]  w_key_sel;
  logic                w_key_load;
  logic [D_WIDTH-1:0]  w_cipher;
  logic                w_unused_key;

  // Only the low D_WIDTH key bits take part in the shift; the reduction keeps
  // the remaining bits formally consumed.
  assign w_unused_key = ^key;

  // Handshakes. busy is exactly "FIFO full", so a push can never overflow.
  assign w_push = valid_i && !r_busy;
  assign w_pop  = (r_count != '0) && (!r_valid_o || ready_i);

  assign w_cipher = data_i + w_key_sel;

  // FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Output stage: load the FIFO head when the slot is free or being consumed,
  // clear to zero when the last word leaves, otherwise hold.
  always_comb begin
    w_valid_d = r_valid_o;
    w_data_d  = r_data_o;
    if (w_pop) begin
      w_valid_d = 1'b1;
      w_data_d  = r_mem[r_rd_ptr];
    end else if (r_valid_o && ready_i) begin
      w_valid_d = 1'b0;
      w_data_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state. ACTIVE ends only once nothing is buffered anywhere and no
  // new word arrives on the same edge.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_push) begin
          w_state_d = StActive;
        end
      end
      StActive: begin
        if (!w_push && (w_count_d == '0) && !w_valid_d) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs. In IDLE the first word uses the live key, which is captured
  // on the same edge for the rest of the burst.
  always_comb begin
    w_key_sel  = r_key_q;
    w_key_load = 1'b0;
    case (r_state)
      StIdle: begin
        w_key_sel  = key[D_WIDTH-1:0];
        w_key_load = w_push;
      end
      StActive: begin
        w_key_sel  = r_key_q;
        w_key_load = 1'b0;
      end
      default: begin
        w_key_sel  = r_key_q;
        w_key_load = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= '0;
    end else if (w_key_load) begin
      r_key_q <= key[D_WIDTH-1:0];
    end
  end

  // Storage array needs no reset: an entry is only read after being written,
  // and reset clears the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cipher;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= w_count_d;
      r_busy  <= (w_count_d == FullCnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      r_data_o  <= w_data_d;
      r_valid_o <= w_valid_d;
    end
  end

  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;
  assign busy    = r_busy;

endmodule

// File: tb/tb_caesar_encryption.sv
// ---------------------------------------------------------------------------
// tb_caesar_encryption
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference (queue of buffered ciphertexts plus one output slot) predicts
// data_o/valid_o/busy after every edge, and every word handed downstream is
// decrypted with the key it was encrypted under and matched to the plaintext
// stream.
// ---------------------------------------------------------------------------
module tb_caesar_encryption;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] key;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        busy;

  caesar_encryption #(
    .D_WIDTH   (8),
    .KEY_WIDTH (16),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .key    (key),
    .ready_i(ready_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0] m_q[$];      // buffered ciphertexts, oldest first
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_busy;
  logic       m_active;
  logic [7:0] m_key;
  logic [7:0] pt_q[$];     // accepted plaintexts awaiting delivery
  logic [7:0] pk_q[$];     // key each of them was encrypted with
  logic [7:0] seen[$];     // words delivered downstream

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    pt_q.delete();
    pk_q.delete();
    m_ov     = 1'b0;
    m_od     = 8'h00;
    m_busy   = 1'b0;
    m_active = 1'b0;
    m_key    = 8'h00;
  endtask

  // Called just before an edge with the inputs the DUT is about to sample.
  task automatic model_edge();
    logic       acc;
    logic       pop;
    logic [7:0] k;
    logic [7:0] rec;
    if (valid_o && ready_i) begin
      check("rt_pending", 32'(pt_q.size() != 0), 32'd1);
      if (pt_q.size() != 0) begin
        rec = data_o - pk_q[0];
        check("roundtrip", 32'(rec), 32'(pt_q[0]));
        void'(pt_q.pop_front());
        void'(pk_q.pop_front());
      end
      seen.push_back(data_o);
    end
    acc = valid_i && !m_busy;
    pop = (m_q.size() != 0) && (!m_ov || ready_i);
    k   = m_active ? m_key : key[7:0];
    if (acc && !m_active) m_key = key[7:0];
    if (pop) begin
      m_od = m_q.pop_front();
      m_ov = 1'b1;
    end else if (m_ov && ready_i) begin
      m_od = 8'h00;
      m_ov = 1'b0;
    end
    if (acc) begin
      m_q.push_back(8'((data_i + k) % 256));
      pt_q.push_back(data_i);
      pk_q.push_back(k);
    end
    m_busy = (m_q.size() == Depth);
    if (acc) m_active = 1'b1;
    else if (m_q.size() == 0 && !m_ov) m_active = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("data_o", 32'(data_o), 32'(m_od));
    check("valid_o", 32'(valid_o), 32'(m_ov));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    rst_n   = 1'b0;
    data_i  = 8'h00;
    valid_i = 1'b0;
    key     = 16'h0000;
    ready_i = 1'b0;
    model_reset();

    // Reset state before any clock edge
    #2;
    check("rst_data_o", 32'(data_o), 32'h0);
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #10;
    rst_n = 1'b1;

    // Basic: 0x41 + 3 -> 0x44, two-edge latency, single-cycle valid
    key = 16'h0003; data_i = 8'h41; valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("basic_lat", 32'(valid_o), 32'h0);
    step();
    check("basic_valid", 32'(valid_o), 32'h1);
    check("basic_data", 32'(data_o), 32'h44);
    step();
    check("basic_drop_v", 32'(valid_o), 32'h0);
    check("basic_drop_d", 32'(data_o), 32'h0);

    // Wrap: upper key byte ignored, 0xFD + 5 wraps to 0x02
    key = 16'h0105; data_i = 8'hFD; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    check("wrap_data", 32'(data_o), 32'h02);
    step();

    // Backpressure: five words fill FIFO + output register, sixth is dropped
    key = 16'h0000; ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_i = 8'(8'h10 + i); valid_i = 1'b1;
      step();
      if (i == 4) check("bp_busy_set", 32'(busy), 32'h1);
    end
    valid_i = 1'b0;
    check("bp_hold_d", 32'(data_o), 32'h10);
    check("bp_hold_busy", 32'(busy), 32'h1);
    seen.delete();
    ready_i = 1'b1;
    step();
    check("bp_busy_clr", 32'(busy), 32'h0);
    check("bp_next", 32'(data_o), 32'h11);
    repeat (5) step();
    check("bp_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) check("bp_order", 32'(seen[i]), 32'(8'h10 + i));
    end
    check("bp_empty", 32'(valid_o), 32'h0);

    // Key lock: key change mid-burst ignored, picked up at next burst
    seen.delete();
    key = 16'h0001; data_i = 8'h20; valid_i = 1'b1;
    step();
    key = 16'h0009;
    step();
    step();
    valid_i = 1'b0;
    repeat (5) step();
    data_i = 8'h20; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (3) step();
    check("lock_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) check("lock_burst", 32'(seen[i]), 32'h21);
    end
    if (seen.size() > 3) check("lock_newkey", 32'(seen[3]), 32'h29);

    // Async reset mid-burst with valid_o=1 and two words buffered
    ready_i = 1'b0; key = 16'h0002; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'(8'h30 + i);
      step();
    end
    valid_i = 1'b0;
    check("ar_pre_valid", 32'(valid_o), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_data_o", 32'(data_o), 32'h0);
    check("ar_valid_o", 32'(valid_o), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    model_reset();
    #10;
    rst_n = 1'b1;
    ready_i = 1'b1;
    repeat (6) step();
    check("ar_no_stale", 32'(valid_o), 32'h0);

    // Randomized traffic with round-trip decryption
    for (int n = 0; n < 400; n++) begin
      valid_i = ($urandom % 10) < 7;
      ready_i = ($urandom % 10) < 6;
      data_i  = 8'($urandom);
      key     = 16'($urandom);
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) step();
    check("rt_drain", 32'(pt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
